window_arbiter: RTL
===================

WINDOW_ARBITER -- requirements
Module: window_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 6, width of the step counter (count range 0..63 at default).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req  input  N_REQ  level request per requester for one counting window.
REQ-006 The block SHALL have port len  input  CNT_W  last step value of the window, sampled at grant.
REQ-007 The block SHALL have port abort  input  1  terminate the running window early.
REQ-008 The block SHALL have port grant  output  N_REQ  one-hot owner of the current window, all-zero when none.
REQ-009 The block SHALL have port busy  output  1  high while a window runs.
REQ-010 The block SHALL have port count  output  CNT_W  current step of the running window.
REQ-011 The block SHALL have port done  output  N_REQ  one-cycle pulse to the owner on normal completion.
REQ-012 The block SHALL have port aborted  output  1  one-cycle pulse on aborted completion.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and GAP, with all outputs registered.
REQ-014 In IDLE with req nonzero, the arbiter SHALL select a winner by round-robin, searching upward from index last_winner+1 with wrap-around modulo N_REQ.
REQ-015 On that edge the FSM SHALL enter RUN, set grant to the one-hot winner, count to 0 and busy to 1, latch len into len_q, and set last_winner to the winner index.
REQ-016 The delay from req asserted in IDLE to grant SHALL be exactly 1 cycle.
REQ-017 In RUN with count != len_q and no abort, count SHALL increment by 1 per cycle while grant is held.
REQ-018 In RUN with count == len_q and no abort, the FSM SHALL enter GAP on the next edge, clearing grant, busy and count and pulsing done[winner] for that GAP cycle.
REQ-019 A granted window SHALL last exactly len_q+1 cycles; len_q=0 SHALL give a 1-cycle window, and the all-ones value SHALL give 2^CNT_W cycles with no counter wrap.
REQ-020 In RUN, abort SHALL take priority over terminal count: the FSM enters GAP, clears grant, busy and count, pulses aborted, and done stays 0.
REQ-021 In GAP, the FSM SHALL return to IDLE unconditionally; consecutive grants are therefore separated by at least 2 grant-free cycles.
REQ-022 Requests SHALL be ignored outside IDLE, and deassertion of the owner's req during RUN SHALL NOT shorten the window.
REQ-023 abort SHALL be ignored in IDLE and GAP.
REQ-024 A change of len during RUN SHALL NOT affect the running window.
REQ-025 At most one bit of grant and done SHALL be high in any cycle; done and aborted SHALL never be high together.

Reset
REQ-026 With rst high at an edge, the next state SHALL be IDLE with grant=0, busy=0, count=0, done=0, aborted=0, len_q=0 and last_winner=N_REQ-1, so that requester 0 has highest priority.
REQ-027 rst asserted mid-window SHALL abandon the window without a done or aborted pulse, and rst SHALL override abort and req.

Verification
REQ-028 Scenario: after reset, req=4'b0110 and len=3 -> grant=4'b0010 one cycle later, count 0,1,2,3 over 4 cycles, then done=4'b0010 for 1 cycle with grant=0.
REQ-029 Scenario: req=4'b1111 held continuously and len=0 -> grants in order 0001, 0010, 0100, 1000, 0001, each a 1-cycle window separated by 2 idle cycles.
REQ-030 Scenario: len=63 with req=4'b0001 -> grant held 64 cycles, count reaches 63, then done=4'b0001 and count=0 with no wrap while granted.
REQ-031 Scenario: abort pulsed when count=10 with len=20 -> next cycle grant=0, aborted=1, done=0, and the FSM is in IDLE one cycle later.
REQ-032 Scenario: rst pulsed when count=5 -> next cycle all outputs 0 with no pulses, and a subsequent req=4'b1000 is granted to requester 3.
REQ-033 Scenario: len changed from 2 to 9 and owner req dropped during RUN -> window still ends after 3 cycles with done asserted.

Source files
------------

// File: rtl/window_arbiter.sv
// rtl/window_arbiter.sv - round-robin arbiter granting bounded counting windows
module window_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [N_REQ-1:0] done,
    output logic             aborted
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] last_winner, last_d;
    logic [N_REQ-1:0] grant_d, done_d;
    logic [CNT_W-1:0] count_d;
    logic             busy_d, aborted_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    int               rr_idx;

    // Round-robin search: first requester found scanning upward from last_winner+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            rr_idx = (int'(last_winner) + i) % N_REQ;
            if (!win_found && req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(rr_idx);
            end
        end
    end

    // Next-state and next-output logic; pulses default low so they last one cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        busy_d    = busy;
        count_d   = count;
        done_d    = '0;
        aborted_d = 1'b0;
        len_d     = len_q;
        last_d    = last_winner;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = RUN;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    busy_d  = 1'b1;
                    count_d = '0;
                    len_d   = len;
                    last_d  = win_idx;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    count_d   = '0;
                    aborted_d = 1'b1;
                end else if (count == len_q) begin
                    state_d = GAP;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    done_d  = grant;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset makes requester 0 highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            count       <= '0;
            done        <= '0;
            aborted     <= 1'b0;
            len_q       <= '0;
            last_winner <= IDX_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            busy        <= busy_d;
            count       <= count_d;
            done        <= done_d;
            aborted     <= aborted_d;
            len_q       <= len_d;
            last_winner <= last_d;
        end
    end

endmodule
